pe_top: RTL and testbench
=========================

Name: pe_top

Overview:
- Memory-mapped single processing element: one unsigned-8 x signed-8 multiply-accumulate (MAC) into a 32-bit signed accumulator.
- Optional ReLU on the read-out view.
- Sits on a simple word-addressed req/wen/addr/wdata/rdata slave bus.
- Software programs operands, pulses start, polls STATUS, then reads RES.

Parameters:
- ADDR_W, 3, word-address width (registers 0..4 used; 5..7 unmapped).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_i  input  1  bus request.
- wen_i  input  4  byte write enables; any nonzero = write, 0 = read.
- addr_i  input  ADDR_W  word address.
- wdata_i  input  32  write data.
- rdata_o  output  32  registered read data.

Behaviour:
- Register map:
  - 0 A: bits[7:0] unsigned operand.
  - 1 B: bits[7:0] signed operand.
  - 2 CTRL: bit0 start, bit1 mode (1 = ReLU), bit2 clear.
  - 3 RES: read-only, signed result.
  - 4 STATUS: read-only, bit0 valid (sticky), bit1 busy.
- Writes: on posedge when req_i=1 and wen_i!=0.
  - A and B store per-byte by wen_i; only bits[7:0] are used.
  - Writes to RES, STATUS and addresses 5..7 are ignored.
- CTRL write with full-byte enable on byte0:
  - start and clear are single-cycle self-clearing pulses, never stored.
  - mode is latched (stored bit).
  - CTRL read returns {29'b0, 0, mode, 0}.
- Clear pulse: acc <= 0 on the next edge. Does not alter valid or RES.
- Start pulse:
  - On the write edge (cycle N): busy=1, valid=0; capture A, B and the written mode.
  - At edge N+1: acc <= acc + $signed({1'b0,A}) * $signed(B), 32-bit two's-complement wraparound.
  - Same edge: RES <= mode ? max(acc_new,0) : acc_new; valid <= 1; busy <= 0.
  - Latency is 1 cycle after the start write.
- Start and clear in the same write: accumulate from zero, so acc = A*B.
- Start while busy: ignored.
- valid stays 1 until the next start. Operand writes while busy do not affect the in-flight op.
- Reads: when req_i=1 and wen_i==0, rdata_o <= register(addr_i) at the edge, available the following cycle.
  - Unmapped addresses read 0.
  - When req_i=0 or a write occurs, rdata_o holds its value.
- Reset (reset=0, async): A, B, acc, RES, mode, valid, busy and rdata_o all clear to 0. Reset mid-operation aborts the op; valid stays 0.

Decomposition:
- Package pe_pkg holds:
  - Address localparams ADDR_A=0, ADDR_B=1, ADDR_CTRL=2, ADDR_RES=3, ADDR_STATUS=4.
  - CTRL bit indices START=0, MODE=1, CLEAR=2.
  - Width constants: 8-bit operands, 32-bit accumulator.
  - Golden functions mac_step(acc,a,b) and out(acc,mode) for the bench.
- Sub-module pe_mac:
  - Inputs: clk, reset, start, clear, a, b, mode.
  - Outputs: acc, result, done.
- pe_top keeps the bus decode, register file, status and read mux.

Test Plan:
- Reset, then read STATUS -> 0 and RES -> 0.
- Clear, then A=5, B=3, start with mode=0 -> STATUS.valid=1 after 1 cycle; RES=15.
- Without clear, A=10, B=-2, mode=0 -> RES=-5. Then A=0, B=0, mode=1 -> RES=0 (ReLU of -5).
- Corner values, continuing from -5:
  - A=255, B=127, mode=0 -> RES=32380.
  - A=255, B=-128, mode=1 -> RES=0 (acc=-260).
- Clear, then 16 ops with a=i and b = i-8 (i even) or 8-i (i odd), then a 0x0 op with mode=1 -> RES=max(sum,0) matching golden; bus reads at address 5 return 0.
- Start and clear in one write with A=7, B=-3 -> RES=-21. Assert reset during busy -> valid=0 and acc=0.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared constants and golden arithmetic for the memory-mapped MAC processing element.
package pe_pkg;

  localparam int unsigned OP_W   = 8;
  localparam int unsigned ACC_W  = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  localparam int unsigned ADDR_A      = 0;
  localparam int unsigned ADDR_B      = 1;
  localparam int unsigned ADDR_CTRL   = 2;
  localparam int unsigned ADDR_RES    = 3;
  localparam int unsigned ADDR_STATUS = 4;

  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_MODE  = 1;
  localparam int unsigned CTRL_CLEAR = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mac_state_e;

  // acc + unsigned a * signed b, wrapping at the accumulator width
  function automatic logic signed [ACC_W-1:0] mac_step(
    input logic signed [ACC_W-1:0] acc,
    input logic        [OP_W-1:0]  a,
    input logic signed [OP_W-1:0]  b
  );
    logic signed [OP_W:0]      sa;
    logic signed [ACC_W-1:0]   prod;
    sa   = signed'({1'b0, a});
    prod = ACC_W'(sa) * ACC_W'(b);
    return acc + prod;
  endfunction

  function automatic logic signed [ACC_W-1:0] out(
    input logic signed [ACC_W-1:0] acc,
    input logic                    mode
  );
    return (mode && acc[ACC_W-1]) ? '0 : acc;
  endfunction

endpackage

// File: rtl/pe_mac.sv
// Single-cycle MAC engine: captures operands on start, accumulates and publishes the result one edge later.
module pe_mac
  import pe_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_i,
  input  logic                    clear_i,
  input  logic        [OP_W-1:0]  a_i,
  input  logic signed [OP_W-1:0]  b_i,
  input  logic                    mode_i,
  output logic signed [ACC_W-1:0] acc_o,
  output logic signed [ACC_W-1:0] result_o,
  output logic                    done_o
);

  mac_state_e              r_state;
  mac_state_e              w_next_state;
  logic        [OP_W-1:0]  r_a;
  logic signed [OP_W-1:0]  r_b;
  logic                    r_mode;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] r_res;
  logic signed [ACC_W-1:0] w_acc_new;
  logic                    r_done;

  always_comb begin
    w_next_state = r_state;
    w_acc_new    = mac_step(r_acc, r_a, r_b);
    case (r_state)
      ST_IDLE: if (start_i) w_next_state = ST_RUN;
      ST_RUN:  w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // clear lands on the write edge, so a combined start+clear accumulates from zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_mode  <= 1'b0;
      r_acc   <= '0;
      r_res   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_RUN) begin
        r_acc  <= w_acc_new;
        r_res  <= out(w_acc_new, r_mode);
        r_done <= 1'b1;
      end else begin
        if (clear_i) r_acc <= '0;
        if (start_i) begin
          r_a    <= a_i;
          r_b    <= b_i;
          r_mode <= mode_i;
          r_done <= 1'b0;
        end
      end
    end
  end

  assign acc_o    = r_acc;
  assign result_o = r_res;
  assign done_o   = r_done;

endmodule

// File: rtl/pe_top.sv
// Bus-attached processing element: register decode, operand/mode storage, status and registered read mux.
module pe_top
  import pe_pkg::*;
#(
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_i,
  input  logic [BE_W-1:0]   wen_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic                      w_wr;
  logic                      w_rd;
  logic                      w_ctrl_wr;
  logic                      w_start;
  logic                      w_clear;
  logic [OP_W-1:0]           r_a;
  logic [OP_W-1:0]           r_b;
  logic                      r_mode;
  logic                      r_busy;
  logic [DATA_W-1:0]         r_rdata;
  logic [DATA_W-1:0]         w_rdata;
  logic signed [ACC_W-1:0]   w_acc_unused;
  logic signed [ACC_W-1:0]   w_result;
  logic                      w_done;
  logic [DATA_W-OP_W-1:0]    w_wdata_hi_unused;

  assign w_wr              = req_i && (wen_i != '0);
  assign w_rd              = req_i && (wen_i == '0);
  assign w_ctrl_wr         = w_wr && wen_i[0] && (addr_i == ADDR_W'(ADDR_CTRL));
  assign w_start           = w_ctrl_wr && wdata_i[CTRL_START] && !r_busy;
  assign w_clear           = w_ctrl_wr && wdata_i[CTRL_CLEAR];
  assign w_wdata_hi_unused = wdata_i[DATA_W-1:OP_W];

  pe_mac u_mac (
    .clk      (clk),
    .reset    (reset),
    .start_i  (w_start),
    .clear_i  (w_clear),
    .a_i      (r_a),
    .b_i      (r_b),
    .mode_i   (wdata_i[CTRL_MODE]),
    .acc_o    (w_acc_unused),
    .result_o (w_result),
    .done_o   (w_done)
  );

  always_comb begin
    w_rdata = '0;
    case (addr_i)
      ADDR_W'(ADDR_A):      w_rdata = DATA_W'(r_a);
      ADDR_W'(ADDR_B):      w_rdata = DATA_W'(r_b);
      ADDR_W'(ADDR_CTRL):   w_rdata = DATA_W'({r_mode, 1'b0});
      ADDR_W'(ADDR_RES):    w_rdata = DATA_W'(w_result);
      ADDR_W'(ADDR_STATUS): w_rdata = DATA_W'({r_busy, w_done});
      default:              w_rdata = '0;
    endcase
  end

  // the engine always finishes one edge after an accepted start, so busy is a one-cycle flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_mode  <= 1'b0;
      r_busy  <= 1'b0;
      r_rdata <= '0;
    end else begin
      if (w_wr && wen_i[0]) begin
        if (addr_i == ADDR_W'(ADDR_A)) r_a <= wdata_i[OP_W-1:0];
        if (addr_i == ADDR_W'(ADDR_B)) r_b <= wdata_i[OP_W-1:0];
      end
      if (w_ctrl_wr) r_mode <= wdata_i[CTRL_MODE];
      r_busy <= w_start;
      if (w_rd) r_rdata <= w_rdata;
    end
  end

  assign rdata_o = r_rdata;

endmodule

// File: tb/tb_pe_top.sv
// Scoreboard bench for pe_top: reads queue their expected data, a monitor checks rdata the cycle after each read.
module tb_pe_top;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic [3:0]  wen;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];

  always #5 clk = ~clk;

  pe_top #(.ADDR_W(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .req_i   (req),
    .wen_i   (wen),
    .addr_i  (addr),
    .wdata_i (wdata),
    .rdata_o (rdata)
  );

  task automatic drv(input logic r, input logic [3:0] w, input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    req = r; wen = w; addr = a; wdata = d;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    drv(1'b1, 4'hF, a, d);
  endtask

  task automatic idle();
    drv(1'b0, 4'h0, 3'd0, 32'd0);
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string n);
    drv(1'b1, 4'h0, a, 32'd0);
    exp_q.push_back(e);
    name_q.push_back(n);
  endtask

  // ctrl: 1=start, 2=mode, 4=clear
  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ctrl);
    wr(3'd0, a);
    wr(3'd1, b);
    wr(3'd2, ctrl);
    idle();
  endtask

  initial begin
    logic [31:0] e;
    string       n;
    forever begin
      @(posedge clk);
      if (reset && req && wen == 4'h0) begin
        #1;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_read: got %h required nothing queued", rdata);
        end else begin
          e = exp_q.pop_front();
          n = name_q.pop_front();
          if (rdata !== e) begin
            bad++;
            $display("FAIL %s: got %h required %h", n, rdata, e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int model;
    int bv;
    reset = 1'b0; req = 1'b0; wen = 4'h0; addr = 3'd0; wdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;

    rd(3'd4, 32'd0, "reset_status");
    rd(3'd3, 32'd0, "reset_res");

    // 5*3; STATUS read on the edge right after start sees busy only
    wr(3'd2, 32'd4);
    wr(3'd0, 32'd5);
    wr(3'd1, 32'd3);
    wr(3'd2, 32'd1);
    rd(3'd4, 32'd2, "status_busy");
    rd(3'd4, 32'd1, "status_valid");
    rd(3'd3, 32'd15, "res_5x3");

    op(32'd10, 32'hFFFF_FFFE, 32'd1);
    rd(3'd3, 32'hFFFF_FFFB, "res_minus5");
    rd(3'd4, 32'd1, "valid_sticky");
    op(32'd0, 32'd0, 32'd3);
    rd(3'd3, 32'd0, "relu_of_minus5");
    rd(3'd2, 32'd2, "ctrl_mode_read");

    op(32'd255, 32'd127, 32'd1);
    rd(3'd3, 32'd32380, "res_255x127");
    op(32'd255, 32'h0000_0080, 32'd3);
    rd(3'd3, 32'd0, "relu_minus260");
    op(32'd0, 32'd0, 32'd1);
    rd(3'd3, 32'hFFFF_FEFC, "acc_minus260");

    wr(3'd0, 32'h1234_56AB);
    rd(3'd0, 32'h0000_00AB, "a_low_byte");
    drv(1'b1, 4'b0010, 3'd0, 32'h0000_00FF);
    rd(3'd0, 32'h0000_00AB, "a_byte1_ignored");

    wr(3'd2, 32'd4);
    model = 0;
    for (int i = 0; i < 16; i++) begin
      bv = (i % 2 == 0) ? (i - 8) : (8 - i);
      model = model + i * bv;
      op(32'(i), 32'(bv), 32'd1);
      rd(3'd3, 32'(model), "loop_res");
    end
    rd(3'd3, 32'hFFFF_FFC8, "loop_sum_minus56");
    op(32'd0, 32'd0, 32'd3);
    rd(3'd3, 32'd0, "loop_relu");
    rd(3'd5, 32'd0, "unmapped_5");
    wr(3'd5, 32'hDEAD_BEEF);
    wr(3'd3, 32'd123);
    rd(3'd5, 32'd0, "unmapped_5_after_wr");
    rd(3'd7, 32'd0, "unmapped_7");
    rd(3'd3, 32'd0, "res_write_ignored");

    // start and clear together
    wr(3'd0, 32'd7);
    wr(3'd1, 32'hFFFF_FFFD);
    rd(3'd1, 32'h0000_00FD, "b_read");
    wr(3'd2, 32'd5);
    idle();
    rd(3'd3, 32'hFFFF_FFEB, "start_clear_minus21");

    // second start while busy is dropped
    wr(3'd2, 32'd4);
    wr(3'd0, 32'd2);
    wr(3'd1, 32'd3);
    wr(3'd2, 32'd1);
    wr(3'd2, 32'd1);
    idle();
    rd(3'd3, 32'd6, "start_while_busy");

    // reset in the busy cycle aborts the op
    wr(3'd2, 32'd1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    req = 1'b0; wen = 4'h0;
    #20;
    @(negedge clk) reset = 1'b1;
    rd(3'd4, 32'd0, "abort_status");
    rd(3'd3, 32'd0, "abort_res");
    op(32'd1, 32'd1, 32'd1);
    rd(3'd3, 32'd1, "acc_zero_after_reset");
    idle();

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d reads pending required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
